// File: rtl/stego_extract_ctrl.sv
// -----------------------------------------------------------------------------
// stego_extract_ctrl
//
// Recovers a hidden message from the edge pixels of a stego image. Each edge
// pixel carries k = 1..6 payload bits taken from the low bits of its r/g/b
// channels. The bits are packed MSB-first into message bytes, and each byte is
// handed to a message RAM through a valid/ready handshake.
//
// Ports
//   clk, rst     system clock; asynchronous active-high reset
//   start        one-cycle request; honoured only in IDLE or DONE
//   mode[5:0]    one-hot bits-per-pixel select (bit n -> n+1 bits per pixel)
//   img_len[15:0] pixels to scan, sampled at an accepted start
//   msg_len[11:0] message bytes to recover, sampled at an accepted start
//   pix_addr     image read address
//   pix_rd       read strobe; pix_data/edge_flag return one cycle later
//   pix_data     pixel {r[7:0], g[7:0], b[7:0]}
//   edge_flag    pixel is an edge pixel and carries payload
//   byte_data    recovered byte
//   byte_addr    message RAM address of byte_data
//   byte_valid / byte_ready   byte handshake
//   busy         high in FETCH, CAPTURE and EMIT
//   done         high in DONE, held until the next accepted start
//   short_msg    image exhausted before msg_len bytes were delivered
//   mode_err     one-cycle pulse for a start with a non-one-hot mode
// -----------------------------------------------------------------------------
module stego_extract_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  mode,
  input  logic [15:0] img_len,
  input  logic [11:0] msg_len,
  output logic [15:0] pix_addr,
  output logic        pix_rd,
  input  logic [23:0] pix_data,
  input  logic        edge_flag,
  output logic [7:0]  byte_data,
  output logic [11:0] byte_addr,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done,
  output logic        short_msg,
  output logic        mode_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EMIT    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // True when exactly one bit of the mode select is set.
  function automatic logic is_one_hot(input logic [5:0] m);
    return (m != 6'd0) && ((m & (m - 6'd1)) == 6'd0);
  endfunction

  // Number of payload bits carried by one edge pixel.
  function automatic logic [3:0] bits_per_pixel(input logic [5:0] m);
    logic [3:0] k;
    case (m)
      6'b000001: k = 4'd1;
      6'b000010: k = 4'd2;
      6'b000100: k = 4'd3;
      6'b001000: k = 4'd4;
      6'b010000: k = 4'd5;
      6'b100000: k = 4'd6;
      default:   k = 4'd0;
    endcase
    return k;
  endfunction

  // Payload bits right-aligned, first-extracted bit in the highest used position.
  // r = px[23:16], g = px[15:8], b = px[7:0].
  function automatic logic [5:0] payload_bits(input logic [5:0] m, input logic [23:0] px);
    logic [5:0] p;
    case (m)
      6'b000001: p = {5'd0, px[0]};
      6'b000010: p = {4'd0, px[16], px[0]};
      6'b000100: p = {3'd0, px[16], px[8], px[0]};
      6'b001000: p = {2'd0, px[16], px[8], px[1:0]};
      6'b010000: p = {1'd0, px[17:16], px[8], px[1:0]};
      6'b100000: p = {px[17:16], px[9:8], px[1:0]};
      default:   p = 6'd0;
    endcase
    return p;
  endfunction

  // Oldest eight bits of an accumulator holding cnt (>= 8) valid bits.
  function automatic logic [7:0] oldest_byte(input logic [12:0] acc, input logic [3:0] cnt);
    logic [12:0] t;
    t = acc >> (cnt - 4'd8);
    return t[7:0];
  endfunction

  // Keep only the cnt youngest bits so stale bits never leak into later bytes.
  function automatic logic [12:0] keep_low(input logic [12:0] acc, input logic [3:0] cnt);
    return acc & ((13'd1 << cnt) - 13'd1);
  endfunction

  state_t      state_r, state_s;
  logic [5:0]  mode_r, mode_s;
  logic [15:0] img_len_r, img_len_s;
  logic [11:0] msg_len_r, msg_len_s;
  logic [15:0] pix_addr_r, pix_addr_s;
  logic [11:0] byte_addr_r, byte_addr_s;
  logic [12:0] acc_r, acc_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [7:0]  byte_data_r, byte_data_s;
  logic        short_msg_r, short_msg_s;
  logic        mode_err_r, mode_err_s;
  logic        pix_rd_r, pix_rd_s;
  logic        byte_valid_r, byte_valid_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;

  logic [3:0]  k_s;
  logic [5:0]  pay_s;
  logic [12:0] acc_cap_s;
  logic [3:0]  cnt_cap_s;
  logic [12:0] acc_after_s;
  logic [3:0]  cnt_after_s;
  logic        unused_pix_s;

  assign k_s       = bits_per_pixel(mode_r);
  assign pay_s     = payload_bits(mode_r, pix_data);
  // Residual never exceeds 7 bits here, so 7 + 6 new bits fit in 13.
  assign acc_cap_s = (acc_r << k_s) | {7'd0, pay_s};
  assign cnt_cap_s = cnt_r + k_s;
  // Only the low channel bits carry payload; the rest are deliberately ignored.
  assign unused_pix_s = ^{pix_data[23:18], pix_data[15:10], pix_data[7:2]};

  // Next-state and next-register computation for the extraction FSM.
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    img_len_s   = img_len_r;
    msg_len_s   = msg_len_r;
    pix_addr_s  = pix_addr_r;
    byte_addr_s = byte_addr_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    byte_data_s = byte_data_r;
    short_msg_s = short_msg_r;
    mode_err_s  = 1'b0;
    acc_after_s = acc_r;
    cnt_after_s = cnt_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (is_one_hot(mode)) begin
            mode_s      = mode;
            img_len_s   = img_len;
            msg_len_s   = msg_len;
            pix_addr_s  = 16'd0;
            byte_addr_s = 12'd0;
            acc_s       = 13'd0;
            cnt_s       = 4'd0;
            if ((msg_len == 12'd0) || (img_len == 16'd0)) begin
              // Nothing to scan or nothing wanted: finish at once.
              state_s     = ST_DONE;
              short_msg_s = (img_len == 16'd0) && (msg_len != 12'd0);
            end else begin
              state_s     = ST_FETCH;
              short_msg_s = 1'b0;
            end
          end else begin
            // Bad mode: flag it and leave every other register untouched.
            mode_err_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_FETCH: begin
        state_s = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // pix_addr stops at img_len so the image is never over-read.
        if (pix_addr_r < img_len_r) begin
          pix_addr_s = pix_addr_r + 16'd1;
        end else begin
          pix_addr_s = pix_addr_r;
        end
        if (edge_flag) begin
          acc_after_s = acc_cap_s;
          cnt_after_s = cnt_cap_s;
        end else begin
          acc_after_s = acc_r;
          cnt_after_s = cnt_r;
        end
        acc_s = acc_after_s;
        cnt_s = cnt_after_s;
        if (cnt_after_s >= 4'd8) begin
          state_s     = ST_EMIT;
          byte_data_s = oldest_byte(acc_after_s, cnt_after_s);
        end else if (pix_addr_s == img_len_r) begin
          state_s     = ST_DONE;
          short_msg_s = 1'b1;
        end else begin
          state_s = ST_FETCH;
        end
      end

      ST_EMIT: begin
        if (byte_ready) begin
          cnt_s       = cnt_r - 4'd8;
          acc_s       = keep_low(acc_r, cnt_r - 4'd8);
          byte_addr_s = byte_addr_r + 12'd1;
          if ((byte_addr_r + 12'd1) == msg_len_r) begin
            // Message complete; any residual bits are simply dropped.
            state_s     = ST_DONE;
            short_msg_s = 1'b0;
          end else if (pix_addr_r == img_len_r) begin
            state_s     = ST_DONE;
            short_msg_s = 1'b1;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they register cleanly.
    pix_rd_s     = (state_s == ST_FETCH);
    byte_valid_s = (state_s == ST_EMIT);
    busy_s       = (state_s == ST_FETCH) || (state_s == ST_CAPTURE) || (state_s == ST_EMIT);
    done_s       = (state_s == ST_DONE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      mode_r       <= 6'd0;
      img_len_r    <= 16'd0;
      msg_len_r    <= 12'd0;
      pix_addr_r   <= 16'd0;
      byte_addr_r  <= 12'd0;
      acc_r        <= 13'd0;
      cnt_r        <= 4'd0;
      byte_data_r  <= 8'd0;
      short_msg_r  <= 1'b0;
      mode_err_r   <= 1'b0;
      pix_rd_r     <= 1'b0;
      byte_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      mode_r       <= mode_s;
      img_len_r    <= img_len_s;
      msg_len_r    <= msg_len_s;
      pix_addr_r   <= pix_addr_s;
      byte_addr_r  <= byte_addr_s;
      acc_r        <= acc_s;
      cnt_r        <= cnt_s;
      byte_data_r  <= byte_data_s;
      short_msg_r  <= short_msg_s;
      mode_err_r   <= mode_err_s;
      pix_rd_r     <= pix_rd_s;
      byte_valid_r <= byte_valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign pix_addr   = pix_addr_r;
  assign pix_rd     = pix_rd_r;
  assign byte_data  = byte_data_r;
  assign byte_addr  = byte_addr_r;
  assign byte_valid = byte_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign short_msg  = short_msg_r;
  assign mode_err   = mode_err_r;

endmodule

// File: tb/tb_stego_extract_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stego_extract_ctrl
//
// Directed bench for stego_extract_ctrl. A small image memory answers pix_rd,
// and a byte sink records every handshake transfer. Inputs change 1 time unit
// after the rising edge, and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_stego_extract_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  mode;
  logic [15:0] img_len;
  logic [11:0] msg_len;
  logic [15:0] pix_addr;
  logic        pix_rd;
  logic [23:0] pix_data = 24'h0;
  logic        edge_flag = 1'b0;
  logic [7:0]  byte_data;
  logic [11:0] byte_addr;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic        short_msg;
  logic        mode_err;

  int errors = 0;
  int checks = 0;
  int cyc;

  logic [23:0] img_mem [16];
  logic        edge_mem [16];
  logic [15:0] rd_q [$];
  logic [11:0] oa_q [$];
  logic [7:0]  od_q [$];

  stego_extract_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .img_len(img_len),
    .msg_len(msg_len), .pix_addr(pix_addr), .pix_rd(pix_rd), .pix_data(pix_data),
    .edge_flag(edge_flag), .byte_data(byte_data), .byte_addr(byte_addr),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .done(done),
    .short_msg(short_msg), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  // Image memory answering reads, plus a log of reads and byte transfers.
  always @(negedge clk) begin
    if (pix_rd === 1'b1) begin
      rd_q.push_back(pix_addr);
      if (pix_addr < 16'd16) begin
        pix_data  = img_mem[pix_addr[3:0]];
        edge_flag = edge_mem[pix_addr[3:0]];
      end else begin
        pix_data  = 24'h0;
        edge_flag = 1'b0;
      end
    end
    if ((byte_valid === 1'b1) && (byte_ready === 1'b1)) begin
      oa_q.push_back(byte_addr);
      od_q.push_back(byte_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input int i, input logic [11:0] ea, input logic [7:0] ed);
    logic [11:0] a;
    logic [7:0]  d;
    a = 12'hxxx;
    d = 8'hxx;
    if (i < od_q.size()) begin
      a = oa_q[i];
      d = od_q[i];
    end else begin
      a = 12'hxxx;
    end
    check({tag, "_addr"}, 32'(a), 32'(ea));
    check({tag, "_data"}, 32'(d), 32'(ed));
  endtask

  task automatic clear_logs();
    rd_q.delete();
    oa_q.delete();
    od_q.delete();
  endtask

  task automatic start_job(input logic [5:0] m, input logic [15:0] il, input logic [11:0] ml);
    mode    = m;
    img_len = il;
    msg_len = ml;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while ((done !== 1'b1) && (c < 300)) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  // Full job with byte_ready high: start, wait for DONE, check the summary flags.
  task automatic run_job(input string tag, input logic [5:0] m, input logic [15:0] il,
                         input logic [11:0] ml, input int exp_cyc, input logic exp_short,
                         input int exp_bytes, input int exp_reads);
    int c;
    clear_logs();
    start_job(m, il, ml);
    wait_done(c);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cycles"}, 32'(c), 32'(exp_cyc));
    check({tag, "_short"}, 32'(short_msg), 32'(exp_short));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_nbytes"}, 32'(od_q.size()), 32'(exp_bytes));
    check({tag, "_nreads"}, 32'(rd_q.size()), 32'(exp_reads));
  endtask

  task automatic load_k6();
    img_mem[0] = 24'hFE06F1;
    img_mem[1] = 24'h55A803;
    img_mem[2] = 24'h0700FF;
    img_mem[3] = 24'h830408;
    for (int i = 0; i < 16; i++) edge_mem[i] = 1'b1;
  endtask

  initial begin
    logic [7:0] kbyte;
    rst        = 1'b0;
    start      = 1'b0;
    mode       = 6'd0;
    img_len    = 16'd0;
    msg_len    = 12'd0;
    byte_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      img_mem[i]  = 24'h0;
      edge_mem[i] = 1'b0;
    end

    // Reset values, applied asynchronously before any clock edge.
    #2 rst = 1'b1;
    #2;
    check("rst_strobes", 32'({pix_rd, byte_valid, busy, done, short_msg, mode_err}), 32'd0);
    check("rst_pix_addr", 32'(pix_addr), 32'd0);
    check("rst_byte_addr", 32'(byte_addr), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    byte_ready = 1'b1;

    // Non-one-hot mode in IDLE: one-cycle mode_err, no activity.
    clear_logs();
    start_job(6'b000011, 16'd4, 12'd1);
    check("moderr_pulse", 32'(mode_err), 32'd1);
    check("moderr_state", 32'({busy, done, pix_rd}), 32'd0);
    @(posedge clk);
    #1;
    check("moderr_clear", 32'(mode_err), 32'd0);
    check("moderr_idle", 32'({busy, done}), 32'd0);
    check("moderr_noread", 32'(rd_q.size()), 32'd0);

    // msg_len = 0 from IDLE: DONE after one edge, no reads, not short.
    clear_logs();
    start_job(6'b000001, 16'd8, 12'd0);
    check("msg0_done", 32'(done), 32'd1);
    check("msg0_short", 32'(short_msg), 32'd0);
    check("msg0_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("msg0_noread", 32'(rd_q.size()), 32'd0);

    // k=6, 4 pixels, 3 bytes: A5, 3C, F0.
    load_k6();
    run_job("k6", 6'b100000, 16'd4, 12'd3, 11, 1'b0, 3, 4);
    check_byte("k6_b0", 0, 12'd0, 8'hA5);
    check_byte("k6_b1", 1, 12'd1, 8'h3C);
    check_byte("k6_b2", 2, 12'd2, 8'hF0);
    check("k6_pix_addr", 32'(pix_addr), 32'd4);

    // Bad mode while in DONE: pulse only, done and short_msg unchanged.
    start_job(6'b000000, 16'd4, 12'd1);
    check("moderr_done_pulse", 32'(mode_err), 32'd1);
    check("moderr_done_held", 32'({done, short_msg}), 32'b10);

    // k=1, alternating edge pixels; odd pixels carry decoy bits. One byte 0x96,
    // then the image runs out. A start mid-run must be ignored.
    kbyte = 8'h96;
    for (int i = 0; i < 16; i++) begin
      if ((i % 2) == 0) begin
        img_mem[i]  = 24'hFFFFFE | {23'd0, kbyte[7 - (i / 2)]};
        edge_mem[i] = 1'b1;
      end else begin
        img_mem[i]  = 24'hFFFFFF;
        edge_mem[i] = 1'b0;
      end
    end
    clear_logs();
    start_job(6'b000001, 16'd16, 12'd2);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    mode  = 6'b100000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 6'b000001;
    check("k1_busy_start_noerr", 32'(mode_err), 32'd0);
    wait_done(cyc);
    check("k1_done", 32'(done), 32'd1);
    check("k1_cycles", 32'(cyc + 5), 32'd33);
    check("k1_short", 32'(short_msg), 32'd1);
    check("k1_nbytes", 32'(od_q.size()), 32'd1);
    check_byte("k1_b0", 0, 12'd0, 8'h96);
    check("k1_nreads", 32'(rd_q.size()), 32'd16);
    check("k1_last_read", 32'(rd_q[$]), 32'd15);
    check("k1_pix_addr_sat", 32'(pix_addr), 32'd16);

    // k=2: {r[0],b[0]}, green set to catch wrong channel, bit1 set to catch wrong bit.
    img_mem[0] = 24'h01FF01;
    img_mem[1] = 24'h02FF02;
    img_mem[2] = 24'h02FF01;
    img_mem[3] = 24'h01FF02;
    for (int i = 0; i < 16; i++) edge_mem[i] = 1'b1;
    run_job("k2", 6'b000010, 16'd4, 12'd1, 9, 1'b0, 1, 4);
    check_byte("k2_b0", 0, 12'd0, 8'hC6);

    // k=3: {r[0],g[0],b[0]} -> 011 011 010, byte 0x6D, one residual bit dropped.
    img_mem[0] = 24'hFE0101;
    img_mem[1] = 24'hFE0101;
    img_mem[2] = 24'h000102;
    run_job("k3", 6'b000100, 16'd3, 12'd1, 7, 1'b0, 1, 3);
    check_byte("k3_b0", 0, 12'd0, 8'h6D);

    // k=4: {r[0],g[0],b[1:0]} -> 1001 1110 = 0x9E.
    img_mem[0] = 24'hFFFEFD;
    img_mem[1] = 24'h0101FE;
    run_job("k4", 6'b001000, 16'd2, 12'd1, 5, 1'b0, 1, 2);
    check_byte("k4_b0", 0, 12'd0, 8'h9E);

    // k=5 with byte_ready held low: 01011 01011 -> 0x5A, residual 2 bits dropped.
    img_mem[0] = 24'hFDFEFF;
    img_mem[1] = 24'hFDFEFF;
    byte_ready = 1'b0;
    clear_logs();
    start_job(6'b010000, 16'd4, 12'd1);
    cyc = 0;
    while ((byte_valid !== 1'b1) && (cyc < 50)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("k5_emit_latency", 32'(cyc), 32'd4);
    check("k5_valid", 32'(byte_valid), 32'd1);
    check("k5_data", 32'(byte_data), 32'h5A);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("k5_hold_valid", 32'(byte_valid), 32'd1);
      check("k5_hold_data", 32'({byte_addr, byte_data}), 32'h0005A);
    end
    byte_ready = 1'b1;
    @(posedge clk);
    #1;
    check("k5_valid_drop", 32'(byte_valid), 32'd0);
    check("k5_done", 32'({done, short_msg}), 32'b10);
    check("k5_nbytes", 32'(od_q.size()), 32'd1);
    check_byte("k5_b0", 0, 12'd0, 8'h5A);
    check("k5_nreads", 32'(rd_q.size()), 32'd2);

    // Reset while byte 1 is offered: valid drops at once, byte not delivered.
    load_k6();
    clear_logs();
    start_job(6'b100000, 16'd4, 12'd3);
    cyc = 0;
    while (!((byte_valid === 1'b1) && (byte_addr === 12'd1)) && (cyc < 50)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rstmid_reached", 32'({byte_valid, byte_addr}), 32'h1001);
    rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(byte_valid), 32'd0);
    check("rstmid_byte_addr", 32'(byte_addr), 32'd0);
    check("rstmid_pix_addr", 32'(pix_addr), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rstmid_nbytes", 32'(od_q.size()), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_job("rerun", 6'b100000, 16'd4, 12'd3, 11, 1'b0, 3, 4);
    check("rerun_first_read", 32'(rd_q[0]), 32'd0);
    check_byte("rerun_b0", 0, 12'd0, 8'hA5);
    check_byte("rerun_b2", 2, 12'd2, 8'hF0);

    // img_len = 0 with bytes wanted: DONE at once and short.
    clear_logs();
    start_job(6'b000100, 16'd0, 12'd5);
    check("img0_done", 32'({done, short_msg, busy}), 32'b110);
    @(posedge clk);
    #1;
    check("img0_noread", 32'(rd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
